// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the parametrised pipeline register
package pipe_pkg;

  localparam logic [15:0] DEFAULT_CTRL_NOP = 16'h0000;

  // D/E control bundle layout; a zero bundle is a safe NOP
  localparam int CTRL_REG_WRITE      = 0;
  localparam int CTRL_RESULT_SRC_LSB = 1;
  localparam int CTRL_RESULT_SRC_W   = 2;
  localparam int CTRL_MEM_WE         = 3;
  localparam int CTRL_JUMP           = 4;
  localparam int CTRL_BRANCH         = 5;
  localparam int CTRL_ALU_CTRL_LSB   = 6;
  localparam int CTRL_ALU_CTRL_W     = 5;
  localparam int CTRL_ALU_SRC        = 11;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline slot: valid/ctrl/data flops with flush-over-stall priority
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 160,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              src_valid_i,
  input  logic [CTRL_W-1:0] src_ctrl_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      if (!stall_i) data_d = src_data_i;
    end else if (!stall_i) begin
      valid_d = src_valid_i;
      // invalid ctrl is never allowed to travel down the pipe
      ctrl_d  = src_valid_i ? src_ctrl_i : CTRL_NOP;
      data_d  = src_data_i;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - DEPTH-slot pipeline register with stall, flush and perf counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 160,
  parameter int                 CTRL_W   = 16,
  parameter int                 DEPTH    = 1,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(DEFAULT_CTRL_NOP),
  parameter int                 CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_i,
  input  logic [DEPTH-1:0]           flush_i,
  input  logic                       clear_cnt_i,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           bubble_cnt_o
);

  localparam int               OCC_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]  slot_valid;
  logic [CTRL_W-1:0] slot_ctrl [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = valid_i;
      assign src_ctrl  = ctrl_i;
      assign src_data  = data_i;
    end else begin : g_chain
      assign src_valid = slot_valid[k-1];
      assign src_ctrl  = slot_ctrl[k-1];
      assign src_data  = slot_data[k-1];
    end

    pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_NOP (CTRL_NOP)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall_i),
      .flush_i     (flush_i[k]),
      .src_valid_i (src_valid),
      .src_ctrl_i  (src_ctrl),
      .src_data_i  (src_data),
      .valid_o     (slot_valid[k]),
      .ctrl_o      (slot_ctrl[k]),
      .data_o      (slot_data[k])
    );
  end

  assign valid_o = slot_valid[DEPTH-1];
  assign ctrl_o  = slot_ctrl[DEPTH-1];
  assign data_o  = slot_data[DEPTH-1];

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_o = occupancy_o + OCC_W'(slot_valid[k]);
    end
  end

  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // a bubble retires when the last slot advances while holding nothing
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clear_cnt_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else if (stall_i) begin
      stall_cnt_d  = CNT_W'(sat_inc(32'(stall_cnt_q), 32'(CNT_MAX)));
    end else if (!valid_o) begin
      bubble_cnt_d = CNT_W'(sat_inc(32'(bubble_cnt_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (DEPTH=3, CNT_W=4)
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;
  localparam logic [CTRL_W-1:0] NOP = 16'h0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_i;
  logic [DEPTH-1:0]  flush_i;
  logic              clear_cnt_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [1:0]        occupancy_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .DEPTH    (DEPTH),
    .CTRL_NOP (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .clear_cnt_i  (clear_cnt_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ctrl_i       (ctrl_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ctrl_o       (ctrl_o),
    .occupancy_o  (occupancy_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  logic was_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // drive inputs before calling; returns just after the next rising edge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) was_stall <= stall_i;

  always @(posedge clk) begin
    #1;
    if (mon_en && !was_stall) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected actual=%0h expected=none", data_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("mon_data", 64'(data_o), 64'(e.data));
          chk("mon_ctrl", 64'(ctrl_o), 64'(e.ctrl));
        end
      end else begin
        chk("mon_bubble_ctrl", 64'(ctrl_o), 64'(NOP));
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = '0; clear_cnt_i = 1'b0;
    valid_i = 1'b0; data_i = '0; ctrl_i = '0;
    step();
    step();
    rst_n = 1'b1;

    // fill the pipe, then assert reset mid-cycle
    valid_i = 1'b1; data_i = 32'hDEADBEEF; ctrl_i = 16'h0033;
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_valid", 64'(valid_o), 64'd1);
    chk("pre_reset_data", 64'(data_o), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ctrl", 64'(ctrl_o), 64'(NOP));
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
    chk("rst_bubble_cnt", 64'(bubble_cnt_o), 64'd0);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // stream 1..6; item 5 is flushed later and never retires
    for (int i = 1; i <= 6; i++) begin
      exp_t e;
      valid_i = 1'b1; data_i = 32'(i); ctrl_i = 16'h00A5; clear_cnt_i = (i == 1);
      e.data = 32'(i); e.ctrl = 16'h00A5;
      if (i != 5) sb.push_back(e);
      step();
      if (i >= 3 && i <= 5) begin
        chk($sformatf("stream_data_%0d", i), 64'(data_o), 64'(i - 2));
        chk("stream_valid", 64'(valid_o), 64'd1);
      end
      if (i == 3) chk("stream_occ", 64'(occupancy_o), 64'd3);
    end
    clear_cnt_i = 1'b0;
    valid_i = 1'b0;
    chk("stream_bubble_cnt", 64'(bubble_cnt_o), 64'd2);

    // stall while full
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_data", 64'(data_o), 64'd4);
    chk("stall_occ", 64'(occupancy_o), 64'd3);
    chk("stall_cnt4", 64'(stall_cnt_o), 64'd4);
    chk("stall_bubble_cnt", 64'(bubble_cnt_o), 64'd2);

    // flush middle slot while stalled
    flush_i = 3'b010;
    step();
    flush_i = '0;
    chk("flush_occ", 64'(occupancy_o), 64'd2);
    chk("flush_out_held", 64'(data_o), 64'd4);
    chk("flush_stall_cnt", 64'(stall_cnt_o), 64'd5);

    // drain with invalid inputs carrying a dirty ctrl
    stall_i = 1'b0; valid_i = 1'b0; ctrl_i = 16'hFFFF; data_i = 32'h77;
    step();
    chk("bubble_at_out", 64'(valid_o), 64'd0);
    chk("bubble_not_yet_counted", 64'(bubble_cnt_o), 64'd2);
    step();
    chk("bubble_retired", 64'(bubble_cnt_o), 64'd3);
    chk("after_bubble_data", 64'(data_o), 64'd6);
    step();
    chk("invalid_valid", 64'(valid_o), 64'd0);
    chk("invalid_ctrl", 64'(ctrl_o), 64'(NOP));
    chk("invalid_occ", 64'(occupancy_o), 64'd0);

    // saturation and clear
    stall_i = 1'b1; clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    chk("sat_cleared", 64'(stall_cnt_o), 64'd0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", 64'(stall_cnt_o), 64'd15);
    chk("sat_bubble_cnt", 64'(bubble_cnt_o), 64'd0);
    clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    chk("clear_wins", 64'(stall_cnt_o), 64'd0);
    stall_i = 1'b0;
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (F/D, D/E, E/M, M/W) of the pipelined RISC-V core.
- Carries a generic data payload and a control bundle through DEPTH chained slots.
- Adds a valid bit, global stall (hold), per-slot flush (bubble insertion), asynchronous reset and saturating stall/bubble performance counters.
- Instantiated between any two stages; the hazard unit drives stall_i and flush_i.

Parameters:
- DATA_W, 160, payload width (rs1/rs2/pc/imm/pc+4 data bits).
- CTRL_W, 16, control bundle width (reg_write, result_src, mem_we, jump, branch, alu_ctrl, alu_src, ...).
- DEPTH, 1, number of chained slots; legal range 1..8.
- CTRL_NOP, '0, control value loaded on bubble/reset; it must encode no reg write, no mem write, no jump, no branch.
- CNT_W, 16, performance counter width.

Ports:
- clk, input, 1, clock; all state updates on the falling edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall_i, input, 1, hold every slot.
- flush_i, input, DEPTH, bit k forces slot k's next value to a bubble.
- clear_cnt_i, input, 1, synchronous clear of both counters.
- valid_i, input, 1, input slot carries a real instruction.
- data_i, input, DATA_W, input payload.
- ctrl_i, input, CTRL_W, input control bundle.
- valid_o, output, 1, last-slot valid.
- data_o, output, DATA_W, last-slot payload.
- ctrl_o, output, CTRL_W, last-slot control (CTRL_NOP when valid_o=0).
- occupancy_o, output, $clog2(DEPTH+1), count of valid slots.
- stall_cnt_o, output, CNT_W, saturating count of stalled edges.
- bubble_cnt_o, output, CNT_W, saturating count of bubbles retired from the last slot.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - every slot: valid=0, ctrl=CTRL_NOP, data=0; both counters 0.
  - Release is synchronous to the next falling edge.
  - Reset mid-stall or mid-flush discards all contents.
- Slot 0 source is the inputs; slot k>0 source is slot k-1 as it stood before the edge.
- Per-slot next state at each falling edge, in priority order:
  - 1. flush_i[k]=1: valid=0, ctrl=CTRL_NOP. Data loads from the source if stall_i=0, otherwise holds. Flush beats stall.
  - 2. stall_i=1: slot holds valid, ctrl and data.
  - 3. Otherwise the slot loads its source. If the source valid is 0, ctrl is forced to CTRL_NOP, so invalid ctrl never propagates.
- Latency: DEPTH falling edges from input to output with no stall; throughput one per cycle.
- Outputs are taken directly from slot DEPTH-1; no combinational input-to-output path.
- Stall with flush_i[0]=1: slot 0 becomes a bubble and the upstream instruction is lost. The upstream stage must re-present it.
- occupancy_o is combinational popcount of the slot valid bits.
- stall_cnt_o: +1 on each edge with stall_i=1.
- bubble_cnt_o: +1 on each edge with stall_i=0 and pre-edge valid_o=0.
- Both counters saturate at 2^CNT_W-1 (no wrap).
- clear_cnt_i=1 zeroes both counters at that edge and wins over a simultaneous increment.

Decomposition:
- Package pipe_pkg holds:
  - DEFAULT_CTRL_NOP constant.
  - ctrl field offset constants for the D/E bundle (reg_write, result_src[1:0], mem_we, jump, branch, alu_ctrl[4:0], alu_src).
  - sat_inc function.
- Sub-module pipe_slot implements one slot (valid/ctrl/data flops with flush/stall priority). The top generates DEPTH pipe_slot instances and adds the counters and popcount.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with valid_i=1, data_i=32'hDEADBEEF -> valid_o=0, ctrl_o=CTRL_NOP, data_o=0 and counters 0 immediately, before any clock edge.
- Streaming, DEPTH=3: ctrl_i=16'h00A5 and data_i=1,2,3 on consecutive edges -> data_o=1,2,3 appear on edges 3,4,5 with valid_o=1 and occupancy_o=3.
- Stall: stall_i=1 for 4 edges while full, DEPTH=3 -> outputs and occupancy frozen; stall_cnt_o=4; bubble_cnt_o unchanged.
- Flush beats stall: stall_i=1 and flush_i=3'b010 on the same edge -> slot 1 valid=0 with ctrl=CTRL_NOP; slots 0 and 2 hold; occupancy_o drops 3->2. The bubble reaches the output and bubble_cnt_o increments once it retires.
- Invalid input: valid_i=0 with ctrl_i=16'hFFFF -> the corresponding output cycle shows ctrl_o=CTRL_NOP and valid_o=0.
- Saturation/clear, CNT_W=4: 20 stalled edges -> stall_cnt_o=15. Then clear_cnt_i=1 together with stall_i=1 -> stall_cnt_o=0.
